// File: rtl/fb_pkg.sv
// Widths, default frame geometry and FSM state type shared by the
// framebuffer read path.
`timescale 1ns/1ps
package fb_pkg;
  localparam int ADDR_W       = 20;
  localparam int PIXEL_W      = 16;
  localparam int IDX_W        = 19;
  localparam int H_PIXELS_DEF = 640;
  localparam int V_LINES_DEF  = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fb_state_t;
endpackage

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO with flush and a registered head. The head
// word is valid in the cycle after it is pushed into an empty FIFO.
`timescale 1ns/1ps
module pixel_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_next;
  logic             push_ok;
  logic             pop_ok;
  logic [CNT_W-1:0] count_after_pop;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    pop_ok          = pop & head_valid;
    push_ok         = push & ((count != CNT_W'(DEPTH)) | pop_ok);
    rd_ptr_next     = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
    count_after_pop = count - CNT_W'(pop_ok);
    count_next      = count_after_pop + CNT_W'(push_ok);
  end

  always_ff @(posedge clock) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr     <= rd_ptr_next;
      count      <= count_next;
      head_valid <= (count_next != '0);
      // A push into an otherwise-empty FIFO bypasses memory to the head.
      if (push_ok && count_after_pop == '0) head_data <= push_data;
      else if (count_after_pop != '0)       head_data <= mem[rd_ptr_next];
    end
  end
endmodule

// File: rtl/framebuffer_reader.sv
// Streams one frame of pixels from the SRAM front buffer in raster order
// into a show-ahead FIFO, with credit-limited reads at fixed latency.
`timescale 1ns/1ps
module framebuffer_reader
  import fb_pkg::*;
#(
  parameter int H_PIXELS     = H_PIXELS_DEF,
  parameter int V_LINES      = V_LINES_DEF,
  parameter int FIFO_DEPTH   = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [ADDR_W-1:0]  front_buffer_addr,
  output logic               read_enable,
  output logic [ADDR_W-1:0]  read_addr,
  input  logic [PIXEL_W-1:0] read_data,
  input  logic               pixel_ready,
  output logic               pixel_valid,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic               frame_done,
  output logic               busy,
  output logic               underflow,
  output fb_state_t          state
);
  localparam int TOTAL = H_PIXELS * V_LINES;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  logic [ADDR_W-1:0]       base;
  logic [IDX_W-1:0]        fetch_index;
  logic [READ_LATENCY-1:0] in_flight_bits;
  logic [CNT_W-1:0]        fifo_count;
  logic                    push;
  logic                    pop;
  logic                    credit_ok;
  logic                    last_pop;
  int                      in_flight;

  // pixel_valid/pixel_ready: a pixel transfers in every cycle both are high;
  // pixel_data holds steady while valid is high and ready is low.
  always_comb begin
    in_flight = int'(read_enable);
    for (int i = 0; i < READ_LATENCY; i++) in_flight += int'(in_flight_bits[i]);
    pop       = pixel_valid & pixel_ready & (state != IDLE) & ~frame_start;
    push      = in_flight_bits[READ_LATENCY-1] & ~frame_start;
    credit_ok = (int'(fifo_count) + in_flight + int'(pop)) < FIFO_DEPTH;
    last_pop  = (state == DRAIN) & pop & (fifo_count == CNT_W'(1)) & (in_flight == 0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      read_enable    <= 1'b0;
      read_addr      <= '0;
      base           <= '0;
      fetch_index    <= '0;
      in_flight_bits <= '0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      frame_done     <= 1'b0;
      in_flight_bits <= (in_flight_bits << 1) | READ_LATENCY'(read_enable);
      if ((state != IDLE) && pixel_ready && !pixel_valid) underflow <= 1'b1;
      if (frame_start) begin
        // Restart: issue the first read right away and drop anything in flight.
        base           <= front_buffer_addr;
        read_enable    <= 1'b1;
        read_addr      <= front_buffer_addr;
        fetch_index    <= IDX_W'(1);
        in_flight_bits <= '0;
        underflow      <= 1'b0;
        busy           <= 1'b1;
        state          <= (LAST_IDX == '0) ? DRAIN : FETCH;
      end else begin
        case (state)
          FETCH: begin
            if (credit_ok) begin
              read_enable <= 1'b1;
              read_addr   <= base + ADDR_W'(fetch_index);
              fetch_index <= fetch_index + 1'b1;
              if (fetch_index == LAST_IDX) state <= DRAIN;
            end else begin
              read_enable <= 1'b0;
            end
          end
          DRAIN: begin
            read_enable <= 1'b0;
            if (last_pop) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end
          end
          default: begin
            read_enable <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

  pixel_fifo #(
    .WIDTH (PIXEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (frame_start),
    .push       (push),
    .push_data  (read_data),
    .pop        (pop),
    .head_valid (pixel_valid),
    .head_data  (pixel_data),
    .count      (fifo_count)
  );
endmodule
